// File: rtl/vmu_data_mux_burst_pkg.sv
// Shared definitions for the VMU burst operand mux: default vector geometry
// and the FSM state encoding.
package vmu_data_mux_burst_pkg;

  localparam int VMU_DATA_WIDTH = 8;  // bits per lane
  localparam int VMU_OP_NUM     = 4;  // lanes per vector beat

  typedef enum logic [1:0] {
    DMUX_IDLE  = 2'd0,
    DMUX_BURST = 2'd1,
    DMUX_DRAIN = 2'd2
  } dmux_state_e;

endpackage

// File: rtl/vmu_skid_buf.sv
// Two-entry valid/ready register stage. The head entry drives the output
// directly, so out_data is always a register. in_ready depends only on the
// occupancy, never on out_ready, which breaks the ready path combinationally.
module vmu_skid_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   count_q;
  logic         push;
  logic         pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Occupancy and entry update: head is the oldest entry, tail the second.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the two data entries are reset too, so out_data reads 0 after reset rather than X.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments make every right-hand side read the pre-edge value.
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= in_data;
          else                 tail_q <= in_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) head_q <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Push is only possible below two entries, so the count stays put.
          if (count_q == 2'd1) begin
            head_q <= in_data;
          end else begin
            head_q <= tail_q;
            tail_q <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vmu_data_mux_burst.sv
// Burst operand mux: selects one of NUM_SRC vector sources and streams a
// programmed number of beats through a skid buffer to the VMU operand bus.
// Optional feature macro: VMU_DMUX_SEL_ERR_EN (reject out-of-range selects
// and raise a sticky sel_err). Without it an out-of-range source behaves as
// an always-valid source of zero data.
module vmu_data_mux_burst
  import vmu_data_mux_burst_pkg::*;
#(
  parameter int DW      = VMU_DATA_WIDTH,
  parameter int LANES   = VMU_OP_NUM,
  parameter int NUM_SRC = 6,
  parameter int SEL_W   = 3,
  parameter int LEN_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [SEL_W-1:0]            sel,
  input  logic [LEN_W-1:0]            len,
  input  logic [NUM_SRC*LANES*DW-1:0] src_data,
  input  logic [NUM_SRC-1:0]          src_valid,
  output logic [NUM_SRC-1:0]          src_ready,
  output logic [LANES*DW-1:0]         out_data,
  output logic                        out_valid,
  output logic                        out_last,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        sel_err
);

  localparam int VW = LANES * DW;

  dmux_state_e      state_q;
  logic [SEL_W-1:0] sel_q;
  logic [LEN_W-1:0] cnt_q;
  logic             done_q;

  logic [VW-1:0]    beat_data;
  logic             beat_valid;
  logic             in_burst;
  logic             skid_ready;
  logic             accept;
  logic             last_beat;
  logic             start_go;

  assign in_burst  = (state_q == DMUX_BURST);
  assign accept    = in_burst && beat_valid && skid_ready;
  assign last_beat = (cnt_q == LEN_W'(1));
  assign busy      = (state_q != DMUX_IDLE);
  assign done      = done_q;

  // Source decode: an index matching no source yields a valid beat of zeros.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    beat_data  = '0;
    beat_valid = 1'b1;
    src_ready  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_q == SEL_W'(i)) begin
        beat_data    = src_data[i*VW +: VW];
        beat_valid   = src_valid[i];
        src_ready[i] = in_burst && skid_ready;
      end
    end
  end

`ifdef VMU_DMUX_SEL_ERR_EN
  logic sel_in_range;
  logic sel_err_q;

  assign sel_in_range = (int'(sel) < NUM_SRC);
  assign start_go     = start && sel_in_range;
  assign sel_err      = sel_err_q;

  // Sticky flag for a start request naming a source that does not exist.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                  sel_err_q <= 1'b0;
    else if (state_q == DMUX_IDLE && start && !sel_in_range)  sel_err_q <= 1'b1;
  end
`else
  assign start_go = start;
  assign sel_err  = 1'b0;
`endif

  // Burst control: latch the request, count accepted beats, wait for drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DMUX_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        DMUX_IDLE: begin
          if (start_go) begin
            sel_q   <= sel;
            cnt_q   <= len;
            state_q <= (len == '0) ? DMUX_DRAIN : DMUX_BURST;
          end
        end
        DMUX_BURST: begin
          if (accept) begin
            cnt_q <= cnt_q - LEN_W'(1);
            if (last_beat) state_q <= DMUX_DRAIN;
          end
        end
        DMUX_DRAIN: begin
          if (!out_valid) begin
            done_q  <= 1'b1;
            state_q <= DMUX_IDLE;
          end
        end
        default: state_q <= DMUX_IDLE;
      endcase
    end
  end

  vmu_skid_buf #(
    .W (VW + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({last_beat, beat_data}),
    .in_valid  (in_burst && beat_valid),
    .in_ready  (skid_ready),
    .out_data  ({out_last, out_data}),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

endmodule

// File: tb/tb_vmu_data_mux_burst.sv
// Directed bench for vmu_data_mux_burst: per-cycle vector table for the
// burst, back-pressure, zero-length, ignored-restart and out-of-range
// scenarios, plus hand-written reset and initial-state sequences.
module tb_vmu_data_mux_burst;
  import vmu_data_mux_burst_pkg::*;

  localparam int VW = VMU_DATA_WIDTH * VMU_OP_NUM;
  localparam int NS = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [2:0]      sel;
  logic [7:0]      len;
  logic [NS*VW-1:0] src_data;
  logic [NS-1:0]   src_valid;
  logic [NS-1:0]   src_ready;
  logic [VW-1:0]   out_data;
  logic            out_valid;
  logic            out_last;
  logic            out_ready;
  logic            busy;
  logic            done;
  logic            sel_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        start;
    logic [2:0]  sel;
    logic [7:0]  len;
    logic [5:0]  valid;
    logic        ordy;
    logic [31:0] d2;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_last;
    logic        e_busy;
    logic        e_done;
    logic [5:0]  e_rdy;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  vmu_data_mux_burst dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sel       (sel),
    .len       (len),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Source 2 carries the per-row word; every other source i holds C0DE000i.
  function automatic logic [NS*VW-1:0] pack_src(input logic [VW-1:0] d2);
    logic [NS*VW-1:0] v;
    v = '0;
    for (int i = 0; i < NS; i++)
      v[i*VW +: VW] = (i == 2) ? d2 : (32'hC0DE_0000 | VW'(i));
    return v;
  endfunction

  function automatic vec_t mk(input logic st, input logic [2:0] sl, input logic [7:0] ln,
                              input logic [5:0] vl, input logic ordy, input logic [31:0] d2,
                              input logic ev, input logic [31:0] ed, input logic el,
                              input logic eb, input logic edn, input logic [5:0] er,
                              input logic ee);
    vec_t v;
    v.start = st;  v.sel = sl;  v.len = ln;  v.valid = vl;  v.ordy = ordy;  v.d2 = d2;
    v.e_valid = ev;  v.e_data = ed;  v.e_last = el;  v.e_busy = eb;  v.e_done = edn;
    v.e_rdy = er;  v.e_err = ee;
    return v;
  endfunction

  // Drive one row at the falling edge, let one rising edge pass, check at the next falling edge.
  task automatic run_vec(input vec_t v, input int idx);
    start     = v.start;
    sel       = v.sel;
    len       = v.len;
    src_valid = v.valid;
    out_ready = v.ordy;
    src_data  = pack_src(v.d2);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("v%0d out_valid", idx), 64'(out_valid), 64'(v.e_valid));
    check($sformatf("v%0d busy", idx),      64'(busy),      64'(v.e_busy));
    check($sformatf("v%0d done", idx),      64'(done),      64'(v.e_done));
    check($sformatf("v%0d src_ready", idx), 64'(src_ready), 64'(v.e_rdy));
    check($sformatf("v%0d sel_err", idx),   64'(sel_err),   64'(v.e_err));
    if (v.e_valid) begin
      check($sformatf("v%0d out_data", idx), 64'(out_data), 64'(v.e_data));
      check($sformatf("v%0d out_last", idx), 64'(out_last), 64'(v.e_last));
    end
  endtask

  initial begin
    localparam logic [5:0] R2 = 6'b000100;
    int beats;
    int dn;
    logic got_done;

    // --- vector table ------------------------------------------------------
    // 1: sel=2 len=4, no back-pressure, beats A..D then drain and done.
    vecs.push_back(mk(1,2,4,6'h3F,1,32'hA, 0,32'h0,0, 1,0,R2,0));
    vecs.push_back(mk(0,2,4,6'h3F,1,32'hA, 1,32'hA,0, 1,0,R2,0));
    vecs.push_back(mk(0,2,4,6'h3F,1,32'hB, 1,32'hB,0, 1,0,R2,0));
    vecs.push_back(mk(0,2,4,6'h3F,1,32'hC, 1,32'hC,0, 1,0,R2,0));
    vecs.push_back(mk(0,2,4,6'h3F,1,32'hD, 1,32'hD,1, 1,0,6'h0,0));
    vecs.push_back(mk(0,2,4,6'h3F,1,32'h0, 0,32'h0,0, 1,0,6'h0,0));
    vecs.push_back(mk(0,2,4,6'h3F,1,32'h0, 0,32'h0,0, 0,1,6'h0,0));
    vecs.push_back(mk(0,2,4,6'h3F,1,32'h0, 0,32'h0,0, 0,0,6'h0,0));
    // 2: same burst with out_ready 1,0,0,1; buffer fills, ready drops, data held.
    vecs.push_back(mk(1,2,4,6'h3F,1,32'hA, 0,32'h0,0, 1,0,R2,0));
    vecs.push_back(mk(0,2,4,6'h3F,1,32'hA, 1,32'hA,0, 1,0,R2,0));
    vecs.push_back(mk(0,2,4,6'h3F,0,32'hB, 1,32'hA,0, 1,0,6'h0,0));
    vecs.push_back(mk(0,2,4,6'h3F,0,32'hC, 1,32'hA,0, 1,0,6'h0,0));
    vecs.push_back(mk(0,2,4,6'h3F,1,32'hC, 1,32'hB,0, 1,0,R2,0));
    vecs.push_back(mk(0,2,4,6'h3F,1,32'hC, 1,32'hC,0, 1,0,R2,0));
    vecs.push_back(mk(0,2,4,6'h3F,1,32'hD, 1,32'hD,1, 1,0,6'h0,0));
    vecs.push_back(mk(0,2,4,6'h3F,1,32'h0, 0,32'h0,0, 1,0,6'h0,0));
    vecs.push_back(mk(0,2,4,6'h3F,1,32'h0, 0,32'h0,0, 0,1,6'h0,0));
    vecs.push_back(mk(0,2,4,6'h3F,1,32'h0, 0,32'h0,0, 0,0,6'h0,0));
    // 3: len=0, one busy cycle then done, no beats.
    vecs.push_back(mk(1,2,0,6'h3F,1,32'h0, 0,32'h0,0, 1,0,6'h0,0));
    vecs.push_back(mk(0,2,0,6'h3F,1,32'h0, 0,32'h0,0, 0,1,6'h0,0));
    vecs.push_back(mk(0,2,0,6'h3F,1,32'h0, 0,32'h0,0, 0,0,6'h0,0));
    // 4: restart with sel=5 len=9 mid-burst is ignored.
    vecs.push_back(mk(1,2,4,6'h3F,1,32'hA, 0,32'h0,0, 1,0,R2,0));
    vecs.push_back(mk(0,5,9,6'h3F,1,32'hA, 1,32'hA,0, 1,0,R2,0));
    vecs.push_back(mk(1,5,9,6'h3F,1,32'hB, 1,32'hB,0, 1,0,R2,0));
    vecs.push_back(mk(0,5,9,6'h3F,1,32'hC, 1,32'hC,0, 1,0,R2,0));
    vecs.push_back(mk(0,5,9,6'h3F,1,32'hD, 1,32'hD,1, 1,0,6'h0,0));
    vecs.push_back(mk(0,5,9,6'h3F,1,32'h0, 0,32'h0,0, 1,0,6'h0,0));
    vecs.push_back(mk(0,5,9,6'h3F,1,32'h0, 0,32'h0,0, 0,1,6'h0,0));
    vecs.push_back(mk(0,5,9,6'h3F,1,32'h0, 0,32'h0,0, 0,0,6'h0,0));
    // 6: sel=7 with only six sources.
`ifdef VMU_DMUX_SEL_ERR_EN
    vecs.push_back(mk(1,7,3,6'h00,1,32'h0, 0,32'h0,0, 0,0,6'h0,1));
    vecs.push_back(mk(0,7,3,6'h00,1,32'h0, 0,32'h0,0, 0,0,6'h0,1));
    vecs.push_back(mk(0,2,3,6'h3F,1,32'h0, 0,32'h0,0, 0,0,6'h0,1));
`else
    vecs.push_back(mk(1,7,3,6'h00,1,32'h5, 0,32'h0,0, 1,0,6'h0,0));
    vecs.push_back(mk(0,7,3,6'h00,1,32'h5, 1,32'h0,0, 1,0,6'h0,0));
    vecs.push_back(mk(0,7,3,6'h00,1,32'h5, 1,32'h0,0, 1,0,6'h0,0));
    vecs.push_back(mk(0,7,3,6'h00,1,32'h5, 1,32'h0,1, 1,0,6'h0,0));
    vecs.push_back(mk(0,7,3,6'h00,1,32'h5, 0,32'h0,0, 1,0,6'h0,0));
    vecs.push_back(mk(0,7,3,6'h00,1,32'h5, 0,32'h0,0, 0,1,6'h0,0));
    vecs.push_back(mk(0,7,3,6'h00,1,32'h5, 0,32'h0,0, 0,0,6'h0,0));
`endif

    // --- reset state --------------------------------------------------------
    rst = 1'b1;  start = 1'b0;  sel = '0;  len = '0;
    src_valid = '0;  out_ready = 1'b0;  src_data = pack_src(32'h0);
    repeat (2) @(negedge clk);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data",  64'(out_data),  64'd0);
    check("reset out_last",  64'(out_last),  64'd0);
    check("reset busy",      64'(busy),      64'd0);
    check("reset done",      64'(done),      64'd0);
    check("reset src_ready", 64'(src_ready), 64'd0);
    check("reset sel_err",   64'(sel_err),   64'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // --- 5: asynchronous reset after beat 2 of an 8-beat burst ---------------
    start = 1'b1;  sel = 3'd1;  len = 8'd8;  src_valid = 6'h3F;  out_ready = 1'b1;
    src_data = pack_src(32'h0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);               // beat 1 accepted
    @(posedge clk);               // beat 2 accepted
    #2 rst = 1'b1;
    #1;
    check("async rst out_valid", 64'(out_valid), 64'd0);
    check("async rst out_data",  64'(out_data),  64'd0);
    check("async rst out_last",  64'(out_last),  64'd0);
    check("async rst busy",      64'(busy),      64'd0);
    check("async rst done",      64'(done),      64'd0);
    check("async rst src_ready", 64'(src_ready), 64'd0);
    check("async rst sel_err",   64'(sel_err),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("no done after rst", 64'(dn), 64'd0);
    check("idle after rst", 64'(busy), 64'd0);

    // New burst on source 3, len=2, must run normally.
    start = 1'b1;  sel = 3'd3;  len = 8'd2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    beats = 0;
    got_done = 1'b0;
    for (int c = 0; c < 30 && !got_done; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        beats++;
        check($sformatf("post-rst beat%0d data", beats), 64'(out_data), 64'h0000_0000_C0DE_0003);
        check($sformatf("post-rst beat%0d last", beats), 64'(out_last), 64'(beats == 2));
      end
      if (done) got_done = 1'b1;
    end
    check("post-rst beat count", 64'(beats), 64'd2);
    check("post-rst done seen",  64'(got_done), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
